// File: rtl/regfile_access_ctrl_pkg.sv
// Shared constants and types for the register-file access controller:
// widths, FSM encoding, ALU opcodes and the latched instruction / output bundles.
package regfile_access_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned RETIRED_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SHL   = 3'd5,
    ALU_SHR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              wb;
  } instr_t;

  typedef struct packed {
    logic                 instr_ready;
    logic                 busy;
    logic                 alu_valid;
    logic                 write_enable;
    logic                 err_timeout;
    logic [ADDR_W-1:0]    read_reg1;
    logic [ADDR_W-1:0]    read_reg2;
    logic [OP_W-1:0]      alu_op;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [ADDR_W-1:0]    write_reg;
    logic [DATA_W-1:0]    write_data;
    logic [RETIRED_W-1:0] retired;
  } ctrl_out_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Decode, register-file and ALU signals seen by the access controller.
// ctrl is the controller side, env is the surrounding datapath side.
interface regfile_access_ctrl_if;
  import regfile_access_ctrl_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OP_W-1:0]      instr_op;
  logic [ADDR_W-1:0]    instr_rs1;
  logic [ADDR_W-1:0]    instr_rs2;
  logic [ADDR_W-1:0]    instr_rd;
  logic                 instr_wb;

  logic [ADDR_W-1:0]    read_reg1;
  logic [ADDR_W-1:0]    read_reg2;
  logic [DATA_W-1:0]    read_data1;
  logic [DATA_W-1:0]    read_data2;
  logic                 write_enable;
  logic [ADDR_W-1:0]    write_reg;
  logic [DATA_W-1:0]    write_data;

  logic                 alu_valid;
  logic [OP_W-1:0]      alu_op;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic                 alu_done;
  logic [DATA_W-1:0]    alu_result;

  logic                 busy;
  logic                 err_timeout;
  logic [RETIRED_W-1:0] retired;

  modport ctrl (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, instr_wb,
    input  read_data1, read_data2, alu_done, alu_result,
    output instr_ready, read_reg1, read_reg2, write_enable, write_reg, write_data,
    output alu_valid, alu_op, alu_a, alu_b, busy, err_timeout, retired
  );

  modport env (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, instr_wb,
    output read_data1, read_data2, alu_done, alu_result,
    input  instr_ready, read_reg1, read_reg2, write_enable, write_reg, write_data,
    input  alu_valid, alu_op, alu_a, alu_b, busy, err_timeout, retired
  );

endinterface

// File: rtl/regfile_access_ctrl.sv
// Sequences one instruction at a time: read operands, hand them to the ALU,
// wait (bounded) for the result, then issue a single-cycle register write-back.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  regfile_access_ctrl_if.ctrl bus
);

  localparam int unsigned TMO_W = $clog2(ALU_TIMEOUT + 1);

  state_e           state_q, state_d;
  instr_t           instr_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  ctrl_out_t        out_q, out_d;
  logic             accept;
  logic             exec_done;
  logic             exec_timeout;

  // State, latched instruction and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      instr_q             <= '0;
      tmo_q               <= '0;
      out_q               <= '0;
      out_q.instr_ready   <= 1'b1;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      out_q   <= out_d;
      if (accept) begin
        instr_q <= '{op: bus.instr_op, rs1: bus.instr_rs1, rs2: bus.instr_rs2,
                     rd: bus.instr_rd, wb: bus.instr_wb};
      end
    end
  end

  // Next state; alu_done only matters in EXEC, and wins over a same-cycle timeout
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    accept       = 1'b0;
    exec_done    = 1'b0;
    exec_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && out_q.instr_ready) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        tmo_d   = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.alu_done) begin
          exec_done = 1'b1;
          state_d   = instr_q.wb ? ST_WRITE : ST_IDLE;
        end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
          exec_timeout = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; address/data fields hold between uses
  always_comb begin
    out_d              = out_q;
    out_d.instr_ready  = (state_d == ST_IDLE);
    out_d.busy         = (state_d != ST_IDLE);
    out_d.alu_valid    = (state_d == ST_EXEC);
    out_d.write_enable = (state_d == ST_WRITE);
    out_d.err_timeout  = exec_timeout;
    if (accept) begin
      out_d.read_reg1 = bus.instr_rs1;
      out_d.read_reg2 = bus.instr_rs2;
      out_d.alu_op    = bus.instr_op;
    end
    if (state_q == ST_READ) begin
      out_d.alu_a = bus.read_data1;
      out_d.alu_b = bus.read_data2;
    end
    if (exec_done) begin
      out_d.write_reg  = instr_q.rd;
      out_d.write_data = bus.alu_result;
    end
    if ((exec_done && !instr_q.wb) || (state_q == ST_WRITE)) begin
      out_d.retired = out_q.retired + RETIRED_W'(1);
    end
  end

  assign bus.instr_ready  = out_q.instr_ready;
  assign bus.busy         = out_q.busy;
  assign bus.alu_valid    = out_q.alu_valid;
  assign bus.write_enable = out_q.write_enable;
  assign bus.err_timeout  = out_q.err_timeout;
  assign bus.read_reg1    = out_q.read_reg1;
  assign bus.read_reg2    = out_q.read_reg2;
  assign bus.alu_op       = out_q.alu_op;
  assign bus.alu_a        = out_q.alu_a;
  assign bus.alu_b        = out_q.alu_b;
  assign bus.write_reg    = out_q.write_reg;
  assign bus.write_data   = out_q.write_data;
  assign bus.retired      = out_q.retired;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: register-file array and ALU behaviour live here; each
// instruction's expected reads, write-back and retire count come from them.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;
  logic [7:0] rf [8];

  always #5 clk = ~clk;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl #(.ALU_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.read_data1 = rf[bus.read_reg1];
  assign bus.read_data2 = rf[bus.read_reg2];

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[2:0];
      3'd6:    return a >> b[2:0];
      default: return b;
    endcase
  endfunction

  function automatic instr_t mk(input int op, input int rs1, input int rs2, input int rd, input int wb);
    return '{op: 3'(op), rs1: 3'(rs1), rs2: 3'(rs2), rd: 3'(rd), wb: 1'(wb)};
  endfunction

  task automatic drive_instr(input instr_t ins);
    bus.instr_op  = ins.op;
    bus.instr_rs1 = ins.rs1;
    bus.instr_rs2 = ins.rs2;
    bus.instr_rd  = ins.rd;
    bus.instr_wb  = ins.wb;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge it is idle again.
  // lat = EXEC cycle on which alu_done is given (0 or > TMO means never).
  task automatic run_instr(input instr_t ins, input int lat, input bit stray,
                           input bit chain, input instr_t nxt, input string tag);
    logic [7:0] a, b, res;
    bit ok;
    a   = rf[ins.rs1];
    b   = rf[ins.rs2];
    res = alu_fn(ins.op, a, b);
    ok  = (lat >= 1) && (lat <= TMO);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle: got %b want 1", tag, bus.instr_ready);
    end
    drive_instr(ins);
    bus.instr_valid = 1'b1;
    bus.alu_done    = stray;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.instr_ready, bus.read_reg1, bus.read_reg2, bus.write_enable, bus.alu_valid, bus.alu_op}
        !== {1'b1, 1'b0, ins.rs1, ins.rs2, 1'b0, 1'b0, ins.op}) begin
      errors++;
      $display("FAIL %s read_phase: got busy=%b rdy=%b r1=%0d r2=%0d we=%b av=%b op=%0d want 1 0 %0d %0d 0 0 %0d",
               tag, bus.busy, bus.instr_ready, bus.read_reg1, bus.read_reg2, bus.write_enable,
               bus.alu_valid, bus.alu_op, ins.rs1, ins.rs2, ins.op);
    end
    if (chain) drive_instr(nxt);
    else bus.instr_valid = 1'b0;
    bus.alu_done = stray;
    @(negedge clk);
    checks++;
    if ({bus.alu_a, bus.alu_b} !== {a, b}) begin
      errors++;
      $display("FAIL %s operands: got a=%0d b=%0d want a=%0d b=%0d", tag, bus.alu_a, bus.alu_b, a, b);
    end
    for (int n = 1; n <= TMO; n++) begin
      checks++;
      if ({bus.alu_valid, bus.busy, bus.instr_ready, bus.write_enable, bus.err_timeout} !== 5'b11000) begin
        errors++;
        $display("FAIL %s exec_cycle%0d: got av,busy,rdy,we,to=%b want 11000", tag, n,
                 {bus.alu_valid, bus.busy, bus.instr_ready, bus.write_enable, bus.err_timeout});
      end
      bus.alu_done   = (n == lat);
      bus.alu_result = (n == lat) ? res : 8'($urandom);
      @(negedge clk);
      bus.alu_done = 1'b0;
      if (n == lat) break;
    end
    if (ok && ins.wb) begin
      checks++;
      if ({bus.write_enable, bus.write_reg, bus.write_data, bus.alu_valid, bus.instr_ready}
          !== {1'b1, ins.rd, res, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s write: got we=%b reg=%0d data=%0d av=%b rdy=%b want 1 %0d %0d 0 0",
                 tag, bus.write_enable, bus.write_reg, bus.write_data, bus.alu_valid, bus.instr_ready,
                 ins.rd, res);
      end
      rf[ins.rd] = res;
      @(negedge clk);
    end
    if (ok) exp_retired = (exp_retired + 1) % 256;
    checks++;
    if ({bus.instr_ready, bus.busy, bus.write_enable, bus.alu_valid, bus.err_timeout, bus.retired}
        !== {1'b1, 1'b0, 1'b0, 1'b0, !ok, 8'(exp_retired)}) begin
      errors++;
      $display("FAIL %s back_idle: got rdy=%b busy=%b we=%b av=%b to=%b ret=%0d want 1 0 0 0 %b %0d",
               tag, bus.instr_ready, bus.busy, bus.write_enable, bus.alu_valid, bus.err_timeout,
               bus.retired, !ok, exp_retired);
    end
    if (!ok && !chain) begin
      @(negedge clk);
      checks++;
      if ({bus.err_timeout, bus.write_enable, bus.busy} !== 3'b000) begin
        errors++;
        $display("FAIL %s timeout_pulse_end: got to,we,busy=%b want 000", tag,
                 {bus.err_timeout, bus.write_enable, bus.busy});
      end
    end
  endtask

  task automatic check_reset_vector(input string tag);
    checks++;
    if ({bus.instr_ready, bus.busy, bus.alu_valid, bus.write_enable, bus.err_timeout, bus.retired,
         bus.read_reg1, bus.read_reg2, bus.alu_op, bus.alu_a, bus.alu_b, bus.write_reg, bus.write_data}
        !== {1'b1, 48'd0}) begin
      errors++;
      $display("FAIL %s reset_vector: got rdy=%b busy=%b av=%b we=%b to=%b ret=%0d r1=%0d r2=%0d op=%0d a=%0d b=%0d wr=%0d wd=%0d want 1 then all 0",
               tag, bus.instr_ready, bus.busy, bus.alu_valid, bus.write_enable, bus.err_timeout,
               bus.retired, bus.read_reg1, bus.read_reg2, bus.alu_op, bus.alu_a, bus.alu_b,
               bus.write_reg, bus.write_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.alu_done    = 1'b0;
    bus.alu_result  = '0;
    drive_instr('0);
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vector("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vector("reset_released");
    exp_retired = 0;
  endtask

  task automatic test_basic();
    rf[0] = 8'd13;
    rf[1] = 8'd25;
    run_instr(mk(ALU_ADD, 0, 1, 2, 1), 1, 1'b0, 1'b0, '0, "basic_add");
    checks++;
    if (bus.retired !== 8'd1) begin
      errors++;
      $display("FAIL basic_retired: got %0d want 1", bus.retired);
    end
  endtask

  task automatic test_no_wb();
    logic [7:0] r3;
    r3 = rf[3];
    run_instr(mk(ALU_SUB, 4, 5, 3, 0), 2, 1'b0, 1'b0, '0, "no_wb");
    checks++;
    if (rf[3] !== r3 || bus.retired !== 8'd2) begin
      errors++;
      $display("FAIL no_wb_state: got r3=%0d ret=%0d want r3=%0d ret=2", rf[3], bus.retired, r3);
    end
  endtask

  task automatic test_timeout();
    run_instr(mk(ALU_XOR, 1, 2, 6, 1), 0, 1'b0, 1'b0, '0, "timeout_never");
    run_instr(mk(ALU_OR, 3, 4, 5, 1), TMO, 1'b0, 1'b0, '0, "done_at_limit");
    run_instr(mk(ALU_AND, 5, 6, 7, 1), TMO + 1, 1'b0, 1'b0, '0, "done_after_limit");
  endtask

  task automatic test_back_to_back();
    instr_t first, second;
    first  = mk(ALU_ADD, 2, 3, 4, 1);
    second = mk(ALU_SUB, 4, 2, 5, 1);
    run_instr(first, 3, 1'b0, 1'b1, second, "b2b_first");
    run_instr(second, 1, 1'b0, 1'b0, '0, "b2b_second");
  endtask

  task automatic test_ignore_done();
    run_instr(mk(ALU_SHL, 6, 7, 7, 1), 2, 1'b1, 1'b0, '0, "stray_done");
    run_instr(mk(ALU_PASSB, 1, 1, 1, 1), 1, 1'b1, 1'b0, '0, "stray_rs_eq_rd");
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] snap [8];
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    drive_instr(mk(ALU_ADD, 0, 1, 3, 1));
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.alu_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_reached: got alu_valid=%b want 1", bus.alu_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vector("mid_exec_reset");
    reset = 1'b0;
    bus.alu_done   = 1'b1;
    bus.alu_result = 8'hA5;
    @(negedge clk);
    bus.alu_done = 1'b0;
    check_reset_vector("mid_exec_after_done");
    @(negedge clk);
    check_reset_vector("mid_exec_settled");
    exp_retired = 0;
    for (int i = 0; i < 8; i++) rf[i] = snap[i];
  endtask

  task automatic test_random(input int count, input bit fast);
    instr_t ins;
    int lat;
    for (int i = 0; i < count; i++) begin
      ins = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1));
      lat = fast ? $urandom_range(1, 2) : $urandom_range(1, 18);
      run_instr(ins, lat, 1'($urandom_range(0, 1)), 1'b0, '0, fast ? "wrap" : "random");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_no_wb();
    test_timeout();
    test_back_to_back();
    test_ignore_done();
    test_random(40, 1'b0);
    test_reset_mid_exec();
    run_instr(mk(ALU_ADD, 2, 2, 2, 1), 1, 1'b0, 1'b0, '0, "after_reset");
    test_random(260, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
